exc_ctrl: RTL and testbench

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl_pkg.sv | 19 +
 rtl/exc_ctrl_irq_sync.sv | 26 ++
 rtl/exc_ctrl.sv | 115 +++++++++++
 tb/tb_exc_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared types and constants for the exception/interrupt controller.
package exc_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StTrap,
    StEret,
    StHold
  } exc_state_e;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  localparam logic [4:0] ExcInt  = 5'd0;
  localparam logic [4:0] ExcAdEL = 5'd4;
  localparam logic [4:0] ExcAdES = 5'd5;
  localparam logic [4:0] ExcRI   = 5'd10;
  localparam logic [4:0] ExcOv   = 5'd12;

endpackage

// File: rtl/exc_ctrl_irq_sync.sv
// Two-stage synchronizer for asynchronous device interrupt lines.
module exc_ctrl_irq_sync #(
  parameter int unsigned Width = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/exc_ctrl.sv
// M-stage exception/interrupt/eret controller driving CP0, flush and redirect.
// Define EXC_CTRL_IRQ_SYNC_EN to pass hw_irq through a 2-flop synchronizer.
module exc_ctrl
  import exc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [4:0]  m_exc,
  input  logic        m_eret,
  input  logic        m_mtc0,
  input  logic [5:0]  hw_irq,
  input  logic        cp0_int_req,
  input  logic [31:0] cp0_epc,
  output logic [31:0] cp0_pc,
  output logic        cp0_bd,
  output logic [4:0]  cp0_exc,
  output logic [5:0]  cp0_hwint,
  output logic        cp0_exl_clr,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  exc_state_e  state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [5:0]  irq_s;
  logic        accept_ok;
  logic        has_exc;

`ifdef EXC_CTRL_IRQ_SYNC_EN
  exc_ctrl_irq_sync #(
    .Width(6)
  ) u_irq_sync (
    .clk(clk),
    .rst(rst),
    .d  (hw_irq),
    .q  (irq_s)
  );
`else
  assign irq_s = hw_irq;
`endif

  // Gated by rst so combinational CP0 drives are also silent during reset.
  assign accept_ok = m_valid && (state_q == StIdle) && !rst;
  assign has_exc   = (m_exc != 5'd0);
  assign cp0_hwint = irq_s & {6{accept_ok}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    epc_d       = epc_q;
    cp0_pc      = '0;
    cp0_bd      = 1'b0;
    cp0_exc     = ExcInt;
    cp0_exl_clr = 1'b0;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    unique case (state_q)
      StIdle: begin
        if (accept_ok) begin
          if (cp0_int_req || has_exc) begin
            cp0_pc  = m_pc;
            cp0_bd  = m_bd;
            cp0_exc = cp0_int_req ? ExcInt : m_exc;
            state_d = StTrap;
          end else if (m_eret) begin
            cp0_exl_clr = 1'b1;
            epc_d       = cp0_epc;
            state_d     = StEret;
          end else if (m_mtc0) begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        // Interrupts stay masked for the cycle after mtc0; exceptions still trap.
        if (m_valid && has_exc && !rst) begin
          cp0_pc  = m_pc;
          cp0_bd  = m_bd;
          cp0_exc = m_exc;
          state_d = StTrap;
        end else begin
          state_d = StIdle;
        end
      end
      StTrap: begin
        flush       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = HANDLER_PC;
        state_d     = StIdle;
      end
      StEret: begin
        flush       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = epc_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: per-cycle directed vectors, expected outputs queued.
module tb_exc_ctrl;

  logic        clk;
  logic        rst;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exc;
  logic        m_eret;
  logic        m_mtc0;
  logic [5:0]  hw_irq;
  logic        cp0_int_req;
  logic [31:0] cp0_epc;
  logic [31:0] cp0_pc;
  logic        cp0_bd;
  logic [4:0]  cp0_exc;
  logic [5:0]  cp0_hwint;
  logic        cp0_exl_clr;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        exl;
    logic        fl;
    logic        rd;
    logic [31:0] rpc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  exc_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .m_valid    (m_valid),
    .m_pc       (m_pc),
    .m_bd       (m_bd),
    .m_exc      (m_exc),
    .m_eret     (m_eret),
    .m_mtc0     (m_mtc0),
    .hw_irq     (hw_irq),
    .cp0_int_req(cp0_int_req),
    .cp0_epc    (cp0_epc),
    .cp0_pc     (cp0_pc),
    .cp0_bd     (cp0_bd),
    .cp0_exc    (cp0_exc),
    .cp0_hwint  (cp0_hwint),
    .cp0_exl_clr(cp0_exl_clr),
    .flush      (flush),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge.
  task automatic drv(input logic r, input logic v, input logic [31:0] pc, input logic bd,
                     input logic [4:0] exc, input logic er, input logic mt,
                     input logic [5:0] irq, input logic ir, input logic [31:0] epc);
    @(posedge clk);
    #1;
    rst = r; m_valid = v; m_pc = pc; m_bd = bd; m_exc = exc;
    m_eret = er; m_mtc0 = mt; hw_irq = irq; cp0_int_req = ir; cp0_epc = epc;
  endtask

  task automatic expect_out(input string nm, input logic [31:0] pc, input logic bd,
                            input logic [4:0] exc, input logic [5:0] hw, input logic exl,
                            input logic fl, input logic rd, input logic [31:0] rpc);
    exp_t e;
    e.name = nm; e.pc = pc; e.bd = bd; e.exc = exc; e.hw = hw;
    e.exl = exl; e.fl = fl; e.rd = rd; e.rpc = rpc;
    exp_q.push_back(e);
  endtask

  task automatic expect_zero(input string nm);
    expect_out(nm, 32'h0, 1'b0, 5'd0, 6'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic expect_redir(input string nm, input logic [31:0] rpc);
    expect_out(nm, 32'h0, 1'b0, 5'd0, 6'h0, 1'b0, 1'b1, 1'b1, rpc);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (cp0_pc !== e.pc || cp0_bd !== e.bd || cp0_exc !== e.exc || cp0_hwint !== e.hw ||
          cp0_exl_clr !== e.exl || flush !== e.fl || redirect !== e.rd ||
          redirect_pc !== e.rpc) begin
        errors++;
        $display("FAIL %s: got pc=%h bd=%b exc=%0d hw=%b exl=%b fl=%b rd=%b rpc=%h | want pc=%h bd=%b exc=%0d hw=%b exl=%b fl=%b rd=%b rpc=%h",
                 e.name, cp0_pc, cp0_bd, cp0_exc, cp0_hwint, cp0_exl_clr, flush, redirect,
                 redirect_pc, e.pc, e.bd, e.exc, e.hw, e.exl, e.fl, e.rd, e.rpc);
      end
    end
  end

  initial begin
    rst = 1'b1; m_valid = 1'b0; m_pc = '0; m_bd = 1'b0; m_exc = '0;
    m_eret = 1'b0; m_mtc0 = 1'b0; hw_irq = '0; cp0_int_req = 1'b0; cp0_epc = '0;

    // Reset hides even an excepting instruction.
    drv(1, 1, 32'h3008, 0, 5'd12, 0, 0, 6'h3f, 1, 32'h0);  expect_zero("reset");
    drv(0, 0, 32'h0, 0, 5'd0, 0, 0, 6'h0, 0, 32'h0);       expect_zero("idle");

    // Overflow exception.
    drv(0, 1, 32'h3008, 0, 5'd12, 0, 0, 6'h0, 0, 32'h0);
    expect_out("exc_detect", 32'h3008, 0, 5'd12, 6'h0, 0, 0, 0, 32'h0);
    drv(0, 1, 32'h5555, 1, 5'd5, 1, 1, 6'h3f, 1, 32'h7777);
    expect_redir("exc_trap", 32'h0000_4180);
    drv(0, 0, 32'h0, 0, 5'd0, 0, 0, 6'h04, 0, 32'h0);      expect_zero("exc_after");
    drv(0, 0, 32'h0, 0, 5'd0, 0, 0, 6'h04, 0, 32'h0);      expect_zero("irq_fill");

    // Interrupt in delay slot beats a pending RI exception.
    drv(0, 1, 32'h3010, 1, 5'd10, 0, 0, 6'h04, 1, 32'h0);
    expect_out("irq_detect", 32'h3010, 1, 5'd0, 6'h04, 0, 0, 0, 32'h0);
    drv(0, 1, 32'h3014, 0, 5'd0, 0, 0, 6'h04, 1, 32'h0);
    expect_redir("irq_trap", 32'h0000_4180);
    drv(0, 0, 32'h0, 0, 5'd0, 0, 0, 6'h0, 0, 32'h0);       expect_zero("irq_after");
    drv(0, 0, 32'h0, 0, 5'd0, 0, 0, 6'h0, 0, 32'h0);       expect_zero("irq_drain");

    // eret: EPC captured at commit, later EPC changes ignored.
    drv(0, 1, 32'h3018, 0, 5'd0, 1, 0, 6'h0, 0, 32'h3020);
    expect_out("eret_exl", 32'h0, 0, 5'd0, 6'h0, 1, 0, 0, 32'h0);
    drv(0, 1, 32'h301c, 0, 5'd12, 0, 0, 6'h0, 1, 32'h1111);
    expect_redir("eret_redir", 32'h3020);
    drv(0, 0, 32'h0, 0, 5'd0, 0, 0, 6'h0, 0, 32'h0);       expect_zero("eret_after");

    // mtc0 masks interrupts for one cycle.
    drv(0, 1, 32'h3028, 0, 5'd0, 0, 1, 6'h0, 0, 32'h0);    expect_zero("mtc0");
    drv(0, 1, 32'h3030, 0, 5'd0, 0, 0, 6'h3f, 1, 32'h0);   expect_zero("hold_mask");
    drv(0, 0, 32'h0, 0, 5'd0, 0, 0, 6'h3f, 1, 32'h0);      expect_zero("bubble_irq1");
    drv(0, 0, 32'h0, 0, 5'd0, 0, 0, 6'h3f, 1, 32'h0);      expect_zero("bubble_irq2");
    drv(0, 1, 32'h3040, 0, 5'd0, 0, 0, 6'h3f, 1, 32'h0);
    expect_out("post_hold_irq", 32'h3040, 0, 5'd0, 6'h3f, 0, 0, 0, 32'h0);
    drv(0, 0, 32'h0, 0, 5'd0, 0, 0, 6'h0, 0, 32'h0);
    expect_redir("post_hold_trap", 32'h0000_4180);
    drv(0, 0, 32'h0, 0, 5'd0, 0, 0, 6'h0, 0, 32'h0);       expect_zero("drain2");

    // HOLD still takes exceptions, interrupt request ignored.
    drv(0, 1, 32'h3048, 0, 5'd0, 0, 1, 6'h0, 0, 32'h0);    expect_zero("mtc0_b");
    drv(0, 1, 32'h3050, 1, 5'd5, 0, 0, 6'h0, 1, 32'h0);
    expect_out("hold_exc", 32'h3050, 1, 5'd5, 6'h0, 0, 0, 0, 32'h0);
    drv(0, 0, 32'h0, 0, 5'd0, 0, 0, 6'h0, 0, 32'h0);
    expect_redir("hold_trap", 32'h0000_4180);

    // Bubbles never take interrupts; exception beats eret.
    drv(0, 0, 32'h0, 0, 5'd12, 0, 0, 6'h3f, 1, 32'h0);     expect_zero("bubble_noirq");
    drv(0, 0, 32'h0, 0, 5'd0, 0, 0, 6'h0, 0, 32'h0);       expect_zero("bubble_b");
    drv(0, 0, 32'h0, 0, 5'd0, 0, 0, 6'h0, 0, 32'h0);       expect_zero("bubble_c");
    drv(0, 1, 32'h3060, 0, 5'd4, 1, 0, 6'h0, 0, 32'h9999);
    expect_out("exc_over_eret", 32'h3060, 0, 5'd4, 6'h0, 0, 0, 0, 32'h0);
    drv(0, 0, 32'h0, 0, 5'd0, 0, 0, 6'h0, 0, 32'h0);
    expect_redir("exc_over_eret_trap", 32'h0000_4180);
    drv(0, 0, 32'h0, 0, 5'd0, 0, 0, 6'h0, 0, 32'h0);       expect_zero("no_eret_after");

    // Reset during TRAP kills flush/redirect immediately and for good.
    drv(0, 1, 32'h3070, 0, 5'd12, 0, 0, 6'h0, 0, 32'h0);
    expect_out("pre_rst_detect", 32'h3070, 0, 5'd12, 6'h0, 0, 0, 0, 32'h0);
    drv(1, 0, 32'h0, 0, 5'd0, 0, 0, 6'h0, 0, 32'h0);       expect_zero("rst_in_trap");
    drv(0, 0, 32'h0, 0, 5'd0, 0, 0, 6'h0, 0, 32'h0);       expect_zero("rst_release");
    drv(0, 0, 32'h0, 0, 5'd0, 0, 0, 6'h0, 0, 32'h0);       expect_zero("rst_after");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
